svi_array_reader: RTL

//  Reader end of an array of 3-signal bus-interface instances (x, y, z per lane).
//  The writer side drives every lane's x to a constant, y to a constant and z from one shared net.

---
 rtl/svi_array_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/svi_array_reader.sv
// svi_array_reader: scans an array of x/y/z lane bundles one lane at a time,
// registers each bundle, flags x/y mismatches against fixed expected values and
// presents the bundle on a valid/ready stream. Mismatching lanes are counted per
// scan with a saturating counter.
module svi_array_reader #(
    parameter int unsigned   N_INST = 4,
    parameter int unsigned   W      = 8,
    parameter logic [W-1:0]  EXP_X  = W'('h00),
    parameter logic [W-1:0]  EXP_Y  = W'('hFF),
    parameter int unsigned   CNT_W  = 8,
    localparam int unsigned  IDX_W  = (N_INST > 1) ? $clog2(N_INST) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_INST*W-1:0] lane_x,
    input  logic [N_INST*W-1:0] lane_y,
    input  logic [N_INST*W-1:0] lane_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic [W-1:0]        out_x,
    output logic [W-1:0]        out_y,
    output logic [W-1:0]        out_z,
    output logic                out_err,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INST - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StPresent,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [W-1:0]       out_x_q, out_x_d;
    logic [W-1:0]       out_y_q, out_y_d;
    logic [W-1:0]       out_z_q, out_z_d;
    logic               out_err_q, out_err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic [W-1:0]       sel_x, sel_y, sel_z;

    // Lane currently addressed by the scan pointer.
    always_comb begin
        sel_x = lane_x[32'(idx_q) * W +: W];
        sel_y = lane_y[32'(idx_q) * W +: W];
        sel_z = lane_z[32'(idx_q) * W +: W];
    end

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StCapture;
                    idx_d       = '0;
                    err_count_d = '0;
                end
            end
            StCapture: begin
                out_x_d     = sel_x;
                out_y_d     = sel_y;
                out_z_d     = sel_z;
                out_idx_d   = idx_q;
                out_err_d   = (sel_x != EXP_X) || (sel_y != EXP_Y);
                out_valid_d = 1'b1;
                state_d     = StPresent;
            end
            StPresent: begin
                // Bundle is frozen until the consumer takes it.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_err_q && (err_count_q != {CNT_W{1'b1}})) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StCapture;
                    end
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_err_q   <= out_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;

    // Scan pointer stays inside the lane array.
    a_idx_bound : assert property (@(posedge clk) disable iff (!rst_n)
        idx_q <= LAST_IDX);

    // A stalled bundle must not change.
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid &&
            $stable({out_idx, out_x, out_y, out_z, out_err})));

    // done is a single-cycle pulse.
    a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule
